// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the data-memory block port between the icache (read-only)
// and the dcache (read/write-back); each cache keeps its private busywait handshake.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_owner_q;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              seen_busy_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              err_q;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the side that did not own the last grant wins.
  always_comb begin
    pick_d = d_req && (!i_req || (last_owner_q == OWN_I));
    cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_D;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      seen_busy_q  <= 1'b0;
      cnt_q        <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            if (pick_d) begin
              owner_q    <= OWN_D;
              op_write_q <= d_write;
              addr_q     <= d_address;
              wdata_q    <= d_writedata;
            end else begin
              owner_q    <= OWN_I;
              op_write_q <= 1'b0;
              addr_q     <= i_address;
              wdata_q    <= '0;
            end
            seen_busy_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          cnt_q <= cnt_d;
          if (32'(cnt_d) >= TIMEOUT) err_q <= 1'b1;
          // Completion needs a busy phase first, so a slow-to-start memory is not mistaken for done.
          if (mem_busywait) begin
            seen_busy_q <= 1'b1;
          end else if (seen_busy_q) begin
            if (!op_write_q) begin
              if (owner_q == OWN_D) d_rdata_q <= mem_readdata;
              else                  i_rdata_q <= mem_readdata;
            end
            last_owner_q <= owner_q;
            state_q      <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read      = (state_q == GRANT) && !op_write_q;
  assign mem_write     = (state_q == GRANT) && op_write_q;
  assign mem_address   = (state_q == GRANT) ? addr_q  : '0;
  assign mem_writedata = (state_q == GRANT) ? wdata_q : '0;

  assign i_busywait = i_req && !((state_q == RELEASE) && (owner_q == OWN_I));
  assign d_busywait = d_req && !((state_q == RELEASE) && (owner_q == OWN_D));

  assign i_readdata  = i_rdata_q;
  assign d_readdata  = d_rdata_q;
  assign err_timeout = err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory block port between the instruction cache (read-only) and the data cache (read and write-back).
- Sits between both cache controllers and the data memory.
- Each cache keeps its existing mem_read/mem_write/mem_busywait handshake unchanged and sees the arbiter as a private memory.
- Grants are round-robin on contention. A granted transaction runs to completion with its request latched, so requester glitches cannot corrupt it.

Parameters:
ADDR_W, 6, block address width (byte address bits [7:2])
DATA_W, 32, block width in bits
TIMEOUT, 255, grant cycles without completion before the error flag sets

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high
i_read  in  1  icache block read request (level, held until i_busywait falls)
i_address  in  ADDR_W  icache block address
i_readdata  out  DATA_W  block returned to icache
i_busywait  out  1  stall to icache
d_read  in  1  dcache block read request
d_write  in  1  dcache write-back request
d_address  in  ADDR_W  dcache block address
d_writedata  in  DATA_W  dcache dirty block
d_readdata  out  DATA_W  block returned to dcache
d_busywait  out  1  stall to dcache
mem_read  out  1  to data memory
mem_write  out  1  to data memory
mem_address  out  ADDR_W  to data memory
mem_writedata  out  DATA_W  to data memory
mem_readdata  in  DATA_W  from data memory
mem_busywait  in  1  from data memory, high while a transaction is in progress
err_timeout  out  1  sticky, a grant exceeded TIMEOUT cycles

Behaviour:
- Clock is clock; reset is synchronous and active-high.
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the memory.
  - RELEASE: one-cycle completion handshake.
- Registers:
  - state
  - owner (I/D)
  - last_owner (I/D)
  - latched op (read/write), address and writedata
  - seen_busy flag
  - 8-bit timeout counter (saturating)
  - i_readdata and d_readdata
  - err_timeout
- Reset: state=IDLE, last_owner=D (so icache wins the first tie), seen_busy=0, counter=0, readdata regs=0, err_timeout=0.
- IDLE, on posedge:
  - Requests are iReq=i_read and dReq=d_read||d_write.
  - Only one requester asserting: grant it.
  - Both asserting: grant the one that is not last_owner.
  - On grant: latch op/address/writedata (d_write takes precedence over d_read if both high), clear seen_busy and counter, go to GRANT.
  - No requests: stay in IDLE.
- GRANT:
  - mem_read/mem_write/mem_address/mem_writedata are driven only from the latched values. Requester input changes are ignored.
  - Each posedge with mem_busywait=1 sets seen_busy.
  - A posedge with seen_busy=1 and mem_busywait=0 completes the transaction:
    - On a read, capture mem_readdata into the owner's readdata register.
    - last_owner<=owner; go to RELEASE.
  - The counter increments every GRANT cycle. Reaching TIMEOUT sets err_timeout (held until reset); the grant continues.
- RELEASE: mem_read=mem_write=0; next posedge always returns to IDLE. This guarantees a ≥1-cycle gap between consecutive memory transactions.
- Memory outputs (IDLE/RELEASE): mem_read=mem_write=0, mem_address=0, mem_writedata=0.
- Requester busywait (combinational):
  - i_busywait = i_read && !(state==RELEASE && owner==I).
  - d_busywait = (d_read||d_write) && !(state==RELEASE && owner==D).
  - A waiting loser therefore stays stalled through the winner's whole transaction.
- Readdata registers hold their values until the next completed read for the same requester.
- Back-to-back: a requester still asserting in the IDLE after its own RELEASE competes normally. Round-robin gives the other side priority if both request.
- Reset mid-GRANT: the next posedge forces IDLE and drops mem_read/mem_write. The data memory is reset in the same cycle.
- Sizing: write-back followed by a refill from dcache uses two separate grants. The icache may be interleaved between them.

Test Plan:
- Memory model with 5-cycle busywait. i_read=1, i_address=6'h0A, mem returns 32'hDEADBEEF -> mem_read high with mem_address=0A during GRANT; i_busywait falls in RELEASE with i_readdata=DEADBEEF; d_busywait stays 0 throughout.
- d_write=1, d_address=6'h15, d_writedata=32'h11223344 -> mem_write=1, mem_address=15, mem_writedata=11223344; d_busywait falls after completion; d_readdata unchanged.
- After reset, i_read and d_read rise on the same cycle (addresses 01/02) -> icache granted first. The dcache is granted in the following IDLE. Repeating with both held gives the order I,D,I,D.
- During an icache grant, change i_address 0A->3F -> mem_address stays 0A until RELEASE.
- mem_busywait held high for 300 cycles -> err_timeout=1 at grant cycle 255 and stays 1 after completion; cleared only by reset.
- Assert reset for one cycle mid-GRANT -> state IDLE, mem_read=mem_write=0, err_timeout=0, readdata regs=0 on the next posedge.
